uart_hex_formatter: RTL and testbench
=====================================

Name: uart_hex_formatter

Overview:
Upstream producer for the UART transmit FIFO. It latches a binary word on a start pulse and writes its ASCII-hex rendering into the TX FIFO, one character per accepted write. The rendering is an optional "0x" prefix, then digits MSB first, then an optional CR LF. It drives the FIFO's wr_uart/w_data inputs and obeys its tx_full flag.

Parameters:
DATA_W, 32, width of word to print; must be a multiple of 4, range 4..64; digit count NIB = DATA_W/4
PREFIX, 1, 1 = emit "0x" (0x30, 0x78) before the digits
NEWLINE, 1, 1 = emit CR LF (0x0D, 0x0A) after the digits
UPPER, 1, 1 = digits A-F as 0x41-0x46; 0 = a-f as 0x61-0x66

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request to print din; sampled only in IDLE
din  input  DATA_W  word to print; latched on accepted start
tx_full  input  1  TX FIFO full flag
wr_uart  output  1  FIFO write strobe; one character per asserted cycle
w_data  output  8  ASCII character; valid whenever wr_uart=1
busy  output  1  high from the cycle after start acceptance until the return to IDLE
done_tick  output  1  one-cycle pulse on the first IDLE cycle after the final character is written

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, digit counter=0, done_tick=0. Outputs wr_uart=0, busy=0, w_data=0x00.
- States: IDLE, PFX0, PFX1, DIGIT, CR, LF.
- IDLE: if start=1, latch din into the shift register, clear the digit counter, clear done_tick, and go to PFX0 (PREFIX=1) or DIGIT (PREFIX=0).
- Emit states (PFX0, PFX1, DIGIT, CR, LF): wr_uart = ~tx_full, combinational from registered state and tx_full. w_data is combinational from state and the shift register's top nibble.
- Advance only in a cycle with wr_uart=1. If tx_full=1, stay in the state; w_data holds the same character and no character is dropped or duplicated.
- Transitions:
  - PFX0 -> PFX1 -> DIGIT.
  - DIGIT: per accepted write, shift the register left 4 and increment the counter. After the write with counter = NIB-1, go to CR (NEWLINE=1) or IDLE.
  - CR -> LF -> IDLE.
- Digit encoding: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10) when UPPER=1, else 0x61+(n-10).
- Total writes per print = 2*PREFIX + NIB + 2*NEWLINE. Defaults: 12.
- Latency: start accepted at edge k; first wr_uart possible in the cycle after edge k. With tx_full=0 throughout, all characters go out on consecutive cycles.
- done_tick:
  - Registered; set on the edge that returns the FSM to IDLE, so it is high for exactly the first IDLE cycle; cleared on the next edge.
  - busy=0 in that same cycle.
  - A start presented in that cycle is accepted (back-to-back prints allowed).
- start while not IDLE is ignored; din changes while busy have no effect.
- Reset asserted mid-print: immediate return to IDLE; wr_uart drops asynchronously; no done_tick. The partial string remains in the FIFO.
- Counter width: clog2(NIB), minimum 1 bit. No wrap beyond NIB-1.

Test Plan:
- Defaults, din=0xDEADBEEF, start pulse, tx_full=0 -> 12 consecutive writes 30 78 44 45 41 44 42 45 45 46 0D 0A. done_tick=1 on the next cycle with busy=0.
- Same stimulus, tx_full forced high for 5 cycles while the 3rd digit (0x41) is presented -> wr_uart=0 for those 5 cycles, w_data held at 0x41. Resume with the identical 12-byte sequence, total 17 busy cycles.
- start pulsed again mid-print with din=0x12345678 -> ignored; output still "0xDEADBEEF\r\n". A start in the done_tick cycle with din=0x00000000 -> "0x00000000\r\n" immediately follows.
- UPPER=0, PREFIX=0, NEWLINE=0, DATA_W=8, din=0xAF -> exactly two writes 0x61 0x66, then done_tick.
- reset driven low after the 4th write of a default print -> wr_uart=0 and busy=0 asynchronously, no done_tick. After release, start with din=0x0000000F -> "0x0000000F\r\n" from the beginning.

Source files
------------

// File: rtl/uart_hex_formatter.sv
// rtl/uart_hex_formatter.sv - renders a binary word as ASCII hex into the UART TX FIFO
module uart_hex_formatter #(
  parameter int DATA_W  = 32,
  parameter int PREFIX  = 1,
  parameter int NEWLINE = 1,
  parameter int UPPER   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              done_tick
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [DATA_W-1:0]  shreg, shreg_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               done_next;
  logic [3:0]         nibble;
  logic               cnt_last;

  // Nibble 0-9 maps to '0'-'9'; 10-15 to upper or lower case letters.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else if (UPPER != 0) begin
      return 8'h41 + {4'h0, n - 4'd10};
    end else begin
      return 8'h61 + {4'h0, n - 4'd10};
    end
  endfunction

  assign nibble   = shreg[DATA_W-1 -: 4];
  assign cnt_last = (cnt == CNT_W'(NIB - 1));
  assign busy     = (state != IDLE);
  // Every non-idle state emits exactly one character; the FIFO full flag gates it.
  assign wr_uart  = (state != IDLE) && !tx_full;

  // Character presented for the current state; held unchanged while stalled.
  always_comb begin
    w_data = 8'h00;
    case (state)
      PFX0:    w_data = 8'h30;
      PFX1:    w_data = 8'h78;
      DIGIT:   w_data = hex_char(nibble);
      CR:      w_data = 8'h0D;
      LF:      w_data = 8'h0A;
      default: w_data = 8'h00;
    endcase
  end

  // Next-state logic: advance only on a cycle where the write is accepted.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_next = din;
          cnt_next   = '0;
          state_next = (PREFIX != 0) ? PFX0 : DIGIT;
        end
      end
      PFX0: begin
        if (wr_uart) state_next = PFX1;
      end
      PFX1: begin
        if (wr_uart) state_next = DIGIT;
      end
      DIGIT: begin
        if (wr_uart) begin
          shreg_next = shreg << 4;
          if (cnt_last) begin
            if (NEWLINE != 0) begin
              state_next = CR;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      CR: begin
        if (wr_uart) state_next = LF;
      end
      LF: begin
        if (wr_uart) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, shift register, digit counter and completion pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      done_tick <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      cnt       <= cnt_next;
      done_tick <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_hex_formatter.sv
// tb/tb_uart_hex_formatter.sv - scoreboard bench for uart_hex_formatter
module tb_uart_hex_formatter;

  logic        clk;
  logic        reset;
  logic        start_a, tx_full_a;
  logic [31:0] din_a;
  logic        wr_a, busy_a, done_a;
  logic [7:0]  w_a;
  logic        start_b, tx_full_b;
  logic [7:0]  din_b;
  logic        wr_b, busy_b, done_b;
  logic [7:0]  w_b;

  int total = 0;
  int bad   = 0;
  int busy_cnt_a = 0;
  int busy_cnt_b = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] exp_byte;

  uart_hex_formatter dut_a (
    .clk(clk), .reset(reset), .start(start_a), .din(din_a), .tx_full(tx_full_a),
    .wr_uart(wr_a), .w_data(w_a), .busy(busy_a), .done_tick(done_a)
  );

  uart_hex_formatter #(.DATA_W(8), .PREFIX(0), .NEWLINE(0), .UPPER(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .din(din_b), .tx_full(tx_full_b),
    .wr_uart(wr_b), .w_data(w_b), .busy(busy_b), .done_tick(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the default instance: every write pops one expected byte.
  always @(negedge clk) begin
    busy_cnt_a += int'(busy_a);
    if (wr_a === 1'b1) begin
      if (qa.size() == 0) begin
        check("unexpected_write_a", {56'h0, w_a}, 64'hFFFF);
      end else begin
        exp_byte = qa.pop_front();
        check("char_a", {56'h0, w_a}, {56'h0, exp_byte});
      end
    end
  end

  // Scoreboard for the small lower-case instance.
  always @(negedge clk) begin
    busy_cnt_b += int'(busy_b);
    if (wr_b === 1'b1) begin
      if (qb.size() == 0) begin
        check("unexpected_write_b", {56'h0, w_b}, 64'hFFFF);
      end else begin
        check("char_b", {56'h0, w_b}, {56'h0, qb.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_hex(input logic [3:0] n, input bit upper);
    if (n < 10) return 8'h30 + n;
    return (upper ? 8'h41 : 8'h61) + (n - 10);
  endfunction

  task automatic push_default(input logic [31:0] w);
    qa.push_back(8'h30);
    qa.push_back(8'h78);
    for (int i = 7; i >= 0; i--) qa.push_back(ref_hex(w[i*4 +: 4], 1'b1));
    qa.push_back(8'h0D);
    qa.push_back(8'h0A);
  endtask

  task automatic start_print_a(input logic [31:0] w);
    din_a   = w;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check(tag, {63'h0, done_a}, 64'h1);
  endtask

  initial begin
    reset = 1'b0;
    start_a = 1'b0; tx_full_a = 1'b0; din_a = '0;
    start_b = 1'b0; tx_full_b = 1'b0; din_b = '0;
    #3;
    check("rst_wr", {63'h0, wr_a}, 64'h0);
    check("rst_busy", {63'h0, busy_a}, 64'h0);
    check("rst_wdata", {56'h0, w_a}, 64'h0);
    check("rst_done", {63'h0, done_a}, 64'h0);
    step();
    step();
    reset = 1'b1;
    step();

    // Plain print with the FIFO always ready.
    push_default(32'hDEADBEEF);
    busy_cnt_a = 0;
    start_print_a(32'hDEADBEEF);
    check("first_wr_latency", {63'h0, wr_a}, 64'h1);
    wait_done_a("done_plain");
    check("done_busy_low", {63'h0, busy_a}, 64'h0);
    check("plain_busy_cycles", 64'(busy_cnt_a), 64'd12);
    check("plain_queue_empty", 64'(qa.size()), 64'd0);
    step();
    check("done_one_cycle", {63'h0, done_a}, 64'h0);

    // FIFO full for five cycles while the third digit is presented.
    push_default(32'hDEADBEEF);
    busy_cnt_a = 0;
    start_print_a(32'hDEADBEEF);
    for (int i = 0; i < 4; i++) step();
    tx_full_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_wr", {63'h0, wr_a}, 64'h0);
      check("stall_hold", {56'h0, w_a}, 64'h41);
      step();
    end
    tx_full_a = 1'b0;
    wait_done_a("done_stall");
    check("stall_busy_cycles", 64'(busy_cnt_a), 64'd17);
    check("stall_queue_empty", 64'(qa.size()), 64'd0);

    // Start mid-print ignored; start in the done cycle accepted.
    step();
    push_default(32'hDEADBEEF);
    start_print_a(32'hDEADBEEF);
    step();
    step();
    din_a = 32'h12345678;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_done_a("done_ignored_start");
    push_default(32'h00000000);
    busy_cnt_a = 0;
    start_print_a(32'h00000000);
    check("b2b_busy", {63'h0, busy_a}, 64'h1);
    check("b2b_first_char", {56'h0, w_a}, 64'h30);
    wait_done_a("done_b2b");
    check("b2b_busy_cycles", 64'(busy_cnt_a), 64'd12);
    check("b2b_queue_empty", 64'(qa.size()), 64'd0);
    step();

    // Small lower-case instance without prefix or newline.
    qb.push_back(8'h61);
    qb.push_back(8'h66);
    busy_cnt_b = 0;
    din_b = 8'hAF;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    step();
    step();
    check("b_done", {63'h0, done_b}, 64'h1);
    check("b_busy_cycles", 64'(busy_cnt_b), 64'd2);
    check("b_queue_empty", 64'(qb.size()), 64'd0);
    step();

    // Reset after the fourth character of a print.
    qa.push_back(8'h30);
    qa.push_back(8'h78);
    qa.push_back(8'h44);
    qa.push_back(8'h45);
    start_print_a(32'hDEADBEEF);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    #1;
    check("rst_mid_wr", {63'h0, wr_a}, 64'h0);
    check("rst_mid_busy", {63'h0, busy_a}, 64'h0);
    check("rst_mid_done", {63'h0, done_a}, 64'h0);
    step();
    check("rst_mid_queue", 64'(qa.size()), 64'd0);
    reset = 1'b1;
    step();
    check("rst_no_done", {63'h0, done_a}, 64'h0);
    push_default(32'h0000000F);
    start_print_a(32'h0000000F);
    wait_done_a("done_after_reset");
    check("after_reset_queue", 64'(qa.size()), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
